alu: RTL and testbench

//  64-bit integer ALU for the pipelined CPU datapath: add, subtract, logic ops and pass-through.

---
 rtl/alu.sv | 86 ++++++++
 tb/tb_alu.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// rtl/alu.sv - 64-bit ALU with combinational result/flags and an NZVC status register
module alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic [2:0]  cntrl,
  input  logic        set_flags,
  output logic [63:0] result,
  output logic        negative,
  output logic        zero,
  output logic        overflow,
  output logic        carry_out,
  output logic        flag_n,
  output logic        flag_z,
  output logic        flag_v,
  output logic        flag_c
);

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;

  logic [64:0] add_sum;
  logic [64:0] sub_sum;
  logic [3:0]  flags_d;
  logic [3:0]  flags_q;

  // Subtraction reuses the adder form A + ~B + 1 so carry means "no borrow".
  assign add_sum = {1'b0, A} + {1'b0, B};
  assign sub_sum = {1'b0, A} + {1'b0, ~B} + 65'd1;

  always_comb begin
    result    = 64'd0;
    overflow  = 1'b0;
    carry_out = 1'b0;
    negative  = 1'b0;
    zero      = 1'b0;
    case (cntrl)
      OP_PASS: result = B;
      OP_ADD: begin
        result    = add_sum[63:0];
        carry_out = add_sum[64];
        overflow  = (A[63] == B[63]) && (add_sum[63] != A[63]);
      end
      OP_SUB: begin
        result    = sub_sum[63:0];
        carry_out = sub_sum[64];
        overflow  = (A[63] != B[63]) && (sub_sum[63] != A[63]);
      end
      OP_AND:  result = A & B;
      OP_OR:   result = A | B;
      OP_XOR:  result = A ^ B;
      default: result = 64'd0;
    endcase
    // Reserved encodings report no flags at all, including zero.
    if (cntrl != 3'b001 && cntrl != 3'b111) begin
      negative = result[63];
      zero     = (result == 64'd0);
    end
  end

  always_comb begin
    flags_d = flags_q;
    if (set_flags) begin
      flags_d = {negative, zero, overflow, carry_out};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_v = flags_q[1];
  assign flag_c = flags_q[0];

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed and randomized self-checking bench for alu
module tb_alu;

  logic        clk;
  logic        reset;
  logic [63:0] A;
  logic [63:0] B;
  logic [2:0]  cntrl;
  logic        set_flags;
  logic [63:0] result;
  logic        negative;
  logic        zero;
  logic        overflow;
  logic        carry_out;
  logic        flag_n;
  logic        flag_z;
  logic        flag_v;
  logic        flag_c;

  int total;
  int bad;

  alu dut (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .B         (B),
    .cntrl     (cntrl),
    .set_flags (set_flags),
    .result    (result),
    .negative  (negative),
    .zero      (zero),
    .overflow  (overflow),
    .carry_out (carry_out),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
    .flag_v    (flag_v),
    .flag_c    (flag_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive operands just after the falling edge so they are stable at the next rising edge.
  task automatic drive(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    cntrl = op;
    A     = a;
    B     = b;
    #1;
  endtask

  task automatic chk_comb(input string tag, input logic [63:0] exp_res, input logic [3:0] exp_nzvc);
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_nzvc"}, {60'd0, negative, zero, overflow, carry_out}, {60'd0, exp_nzvc});
  endtask

  task automatic chk_reg(input string tag, input logic [3:0] exp_nzvc);
    chk(tag, {60'd0, flag_n, flag_z, flag_v, flag_c}, {60'd0, exp_nzvc});
  endtask

  // Reference built from unsigned/signed comparisons rather than the adder carry chain.
  task automatic model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] r, output logic [3:0] f);
    logic v;
    logic c;
    v = 1'b0;
    c = 1'b0;
    case (op)
      3'b000: r = b;
      3'b010: begin
        r = a + b;
        c = (r < a);
        v = (!a[63] && !b[63] && r[63]) || (a[63] && b[63] && !r[63]);
      end
      3'b011: begin
        r = a - b;
        c = (a >= b);
        v = ($signed(a) >= $signed(b)) ? r[63] : !r[63];
      end
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: r = a ^ b;
      default: r = 64'd0;
    endcase
    f = {r[63], (r == 64'd0), v, c};
  endtask

  initial begin
    logic [2:0]  ops [6];
    logic [63:0] ra;
    logic [63:0] rb;
    logic [63:0] er;
    logic [3:0]  ef;
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    set_flags = 1'b1;
    cntrl     = 3'b010;
    A         = 64'h7FFF_FFFF_FFFF_FFFF;
    B         = 64'd1;

    // Reset wins over set_flags even though the live flags are non-zero.
    @(posedge clk); #1;
    chk_reg("reset_flags", 4'b0000);
    chk_comb("comb_during_reset", 64'h8000_0000_0000_0000, 4'b1010);

    @(negedge clk);
    reset     = 1'b0;
    set_flags = 1'b0;

    drive(3'b010, 64'd5, 64'd7);
    chk_comb("add_5_7", 64'd12, 4'b0000);
    drive(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    chk_comb("add_ovf", 64'h8000_0000_0000_0000, 4'b1010);
    drive(3'b011, 64'd3, 64'd3);
    chk_comb("sub_3_3", 64'd0, 4'b0101);
    drive(3'b011, 64'd0, 64'd1);
    chk_comb("sub_0_1", 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000);
    drive(3'b011, 64'h8000_0000_0000_0000, 64'd1);
    chk_comb("sub_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011);
    drive(3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    chk_comb("add_wrap", 64'd0, 4'b0101);
    drive(3'b100, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
    chk_comb("and", 64'hF000_F000_F000_F000, 4'b1000);
    drive(3'b101, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
    chk_comb("or", 64'hFFF0_FFF0_FFF0_FFF0, 4'b1000);
    drive(3'b110, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
    chk_comb("xor", 64'h0FF0_0FF0_0FF0_0FF0, 4'b0000);
    drive(3'b000, 64'h1234, 64'd0);
    chk_comb("pass_zero", 64'd0, 4'b0100);
    drive(3'b000, 64'h1234, 64'hFF00_FF00_FF00_FF00);
    chk_comb("pass_neg", 64'hFF00_FF00_FF00_FF00, 4'b1000);
    drive(3'b001, 64'd5, 64'd7);
    chk_comb("rsv_001", 64'd0, 4'b0000);
    drive(3'b111, 64'd0, 64'd0);
    chk_comb("rsv_111", 64'd0, 4'b0000);
    chk_reg("flags_idle", 4'b0000);

    // Status register: load, hold, reload, then reset mid-sequence.
    drive(3'b011, 64'd3, 64'd3);
    set_flags = 1'b1;
    @(posedge clk); #1;
    chk_reg("flags_sub_3_3", 4'b0101);
    drive(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    set_flags = 1'b0;
    @(posedge clk); #1;
    chk_reg("flags_hold", 4'b0101);
    set_flags = 1'b1;
    @(posedge clk); #1;
    chk_reg("flags_add_ovf", 4'b1010);
    drive(3'b011, 64'd0, 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_reg("flags_mid_reset", 4'b0000);
    @(negedge clk);
    reset     = 1'b0;
    set_flags = 1'b0;

    ops = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 16; j++) begin
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        if (j == 0) rb = ra;
        model(ops[i], ra, rb, er, ef);
        drive(ops[i], ra, rb);
        chk_comb($sformatf("rand_op%0d_%0d", ops[i], j), er, ef);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
